// File: rtl/hack_mem_arbiter_pkg.sv
// Shared HACK memory-system constants: bus widths, screen base address and requester IDs.
// Also used by the screen controller and the RAM wrapper.
package hack_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;
  localparam int SCR_W  = 13;
  localparam logic [ADDR_W-1:0] SCREEN_BASE = 15'h4000;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_SCR = 1'b1
  } req_id_e;

  // Screen offsets wrap inside the RAM address space; there is no overflow flag.
  function automatic logic [ADDR_W-1:0] scr_to_ram(input logic [ADDR_W-1:0] base,
                                                   input logic [SCR_W-1:0]  off);
    return base + ADDR_W'(off);
  endfunction

endpackage

// File: rtl/hack_mem_arbiter_if.sv
// Bundle of CPU data port, screen read port and RAM port around the memory arbiter.
// The master side is the requesters plus the RAM; the slave side is the arbiter.
interface hack_mem_arbiter_if;
  import hack_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              scr_req;
  logic [SCR_W-1:0]  scr_addr;
  logic              scr_gnt;
  logic              scr_rvalid;
  logic [DATA_W-1:0] scr_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output scr_req, scr_addr,
    input  scr_gnt, scr_rvalid, scr_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  scr_req, scr_addr,
    output scr_gnt, scr_rvalid, scr_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

endinterface

// File: rtl/hack_mem_arbiter_rr_arb2.sv
// Two-input round-robin picker; last records who was served most recently.
// Coming out of reset last = screen, so the CPU wins the first contended cycle.
module rr_arb2
  import hack_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_e last;

  always_comb begin
    gnt = 2'b00;
    if (!reset) begin
      if (req == 2'b11) gnt = (last == REQ_SCR) ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       last <= REQ_SCR;
    else if (gnt[0]) last <= REQ_CPU;
    else if (gnt[1]) last <= REQ_SCR;
  end

endmodule

// File: rtl/hack_mem_arbiter.sv
// Shares the single-port data RAM between the CPU data port and screen scan-out.
// Grants are same-cycle; read data is steered back one cycle after the grant.
module hack_mem_arbiter
  import hack_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SCREEN_BASE_P = SCREEN_BASE
) (
  input logic             clk,
  input logic             reset,
  hack_mem_arbiter_if.slave bus
);

  logic [1:0] req;
  logic [1:0] gnt;
  logic [1:0] pend;

  assign req = {bus.scr_req, bus.cpu_req};

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .gnt   (gnt)
  );

  assign bus.cpu_gnt = gnt[REQ_CPU];
  assign bus.scr_gnt = gnt[REQ_SCR];

  // Idle RAM port is driven to all zeros so nothing stale leaks onto the bus.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (gnt[REQ_CPU]) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (gnt[REQ_SCR]) begin
      bus.mem_en    = 1'b1;
      bus.mem_addr  = scr_to_ram(SCREEN_BASE_P, bus.scr_addr);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= 2'b00;
    end else begin
      pend[REQ_CPU] <= gnt[REQ_CPU] & ~bus.cpu_we;
      pend[REQ_SCR] <= gnt[REQ_SCR];
    end
  end

  // Masking with reset keeps a read granted just before reset from surfacing.
  assign bus.cpu_rvalid = pend[REQ_CPU] & ~reset;
  assign bus.scr_rvalid = pend[REQ_SCR] & ~reset;
  assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : '0;
  assign bus.scr_rdata  = bus.scr_rvalid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_hack_mem_arbiter.sv
// Directed bench for hack_mem_arbiter with a behavioural RAM and a read-data scoreboard.
module tb_hack_mem_arbiter;
  import hack_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hack_mem_arbiter_if bus ();

  hack_mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] ram    [0:32767];
  logic [15:0] shadow [0:32767];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  typedef struct packed {
    logic        v;
    logic [15:0] d;
  } exp_t;

  exp_t cpu_q[$];
  exp_t scr_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit creq, input bit cwe,
                      input logic [14:0] caddr, input logic [15:0] cwd,
                      input bit sreq, input logic [12:0] saddr,
                      input bit ecg, input bit esg);
    exp_t ce, se, cn, sn;
    logic [14:0] sram;
    @(negedge clk);
    reset         = rst;
    bus.cpu_req   = creq;
    bus.cpu_we    = cwe;
    bus.cpu_addr  = caddr;
    bus.cpu_wdata = cwd;
    bus.scr_req   = sreq;
    bus.scr_addr  = saddr;
    #1;
    ce = cpu_q.pop_front();
    se = scr_q.pop_front();
    if (rst) begin
      ce = '0;
      se = '0;
    end
    check("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(ce.v));
    check("cpu_rdata",  32'(bus.cpu_rdata),  ce.v ? 32'(ce.d) : 32'h0);
    check("scr_rvalid", 32'(bus.scr_rvalid), 32'(se.v));
    check("scr_rdata",  32'(bus.scr_rdata),  se.v ? 32'(se.d) : 32'h0);
    check("cpu_gnt",    32'(bus.cpu_gnt),    32'(ecg));
    check("scr_gnt",    32'(bus.scr_gnt),    32'(esg));
    sram = 15'h4000 + {2'b00, saddr};
    if (ecg) begin
      check("mem_en_cpu",   32'(bus.mem_en),    32'h1);
      check("mem_we_cpu",   32'(bus.mem_we),    32'(cwe));
      check("mem_addr_cpu", 32'(bus.mem_addr),  32'(caddr));
      if (cwe) check("mem_wdata_cpu", 32'(bus.mem_wdata), 32'(cwd));
    end else if (esg) begin
      check("mem_en_scr",   32'(bus.mem_en),   32'h1);
      check("mem_we_scr",   32'(bus.mem_we),   32'h0);
      check("mem_addr_scr", 32'(bus.mem_addr), 32'(sram));
    end else begin
      check("mem_en_idle", 32'(bus.mem_en), 32'h0);
    end
    if (rst) begin
      check("mem_we_rst",    32'(bus.mem_we),    32'h0);
      check("mem_addr_rst",  32'(bus.mem_addr),  32'h0);
      check("mem_wdata_rst", 32'(bus.mem_wdata), 32'h0);
    end
    cn = '0;
    sn = '0;
    if (ecg && !cwe) cn = {1'b1, shadow[caddr]};
    if (ecg && cwe)  shadow[caddr] = cwd;
    if (esg)         sn = {1'b1, shadow[sram]};
    cpu_q.push_back(cn);
    scr_q.push_back(sn);
  endtask

  task automatic idle();
    step(0, 0, 0, 15'h0, 16'h0, 0, 13'h0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      ram[i]    = 16'(i * 7) ^ 16'hC3C3;
      shadow[i] = 16'(i * 7) ^ 16'hC3C3;
    end
    ram[15'h0010] = 16'hBEEF;  shadow[15'h0010] = 16'hBEEF;
    ram[15'h4005] = 16'h1234;  shadow[15'h4005] = 16'h1234;
    ram[15'h5FFF] = 16'h7E57;  shadow[15'h5FFF] = 16'h7E57;
    bus.mem_rdata = 16'h0;
    reset = 1'b1;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.scr_req = 0; bus.scr_addr = '0;
    cpu_q.push_back('0);
    scr_q.push_back('0);

    // reset holds everything low even with both requesting
    step(1, 1, 0, 15'h0010, 16'h0, 1, 13'h0005, 0, 0);
    step(1, 1, 0, 15'h0010, 16'h0, 1, 13'h0005, 0, 0);

    // single CPU read, then screen reads incl. top offset
    step(0, 1, 0, 15'h0010, 16'h0, 0, 13'h0,    1, 0);
    step(0, 0, 0, 15'h0,    16'h0, 1, 13'h0005, 0, 1);
    step(0, 0, 0, 15'h0,    16'h0, 1, 13'h1FFF, 0, 1);
    idle();

    // continuous contention straight out of reset alternates CPU first
    step(1, 0, 0, 15'h0, 16'h0, 0, 13'h0, 0, 0);
    for (int k = 0; k < 6; k++)
      step(0, 1, 0, 15'h0020, 16'h0, 1, 13'h0010, (k % 2) == 0, (k % 2) == 1);
    idle();

    // write then read-back, back-to-back sole requester
    step(0, 1, 1, 15'h0100, 16'hA5A5, 0, 13'h0, 1, 0);
    step(0, 1, 0, 15'h0100, 16'h0,    0, 13'h0, 1, 0);
    idle();

    // reset right after a CPU read grant suppresses its rvalid
    step(0, 1, 0, 15'h0010, 16'h0, 0, 13'h0,    1, 0);
    step(1, 1, 0, 15'h0010, 16'h0, 1, 13'h0005, 0, 0);
    step(0, 1, 0, 15'h0010, 16'h0, 1, 13'h0005, 1, 0);
    step(0, 1, 0, 15'h0010, 16'h0, 1, 13'h0005, 0, 1);
    idle();

    // CPU read followed by sole screen read: rvalids on consecutive cycles
    step(0, 1, 0, 15'h0010, 16'h0, 0, 13'h0,    1, 0);
    step(0, 0, 0, 15'h0,    16'h0, 1, 13'h0005, 0, 1);
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
